// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the iterative multiply/divide unit.
//   - MDop encodings for the operations the unit understands
//   - FSM state type (IDLE / MUL / DIV)
//   - MD_LAT: cycles from accept to result for MULT/MULTU/DIV/DIVU
package md_pkg;

  localparam int MD_LAT = 32;

  // MDop encodings; 3'b110 and 3'b111 are no-ops.
  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MTHI  = 3'b100,
    MD_MTLO  = 3'b101
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } md_state_e;

  // Signed variants work on magnitudes and fix the sign up at the end.
  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// md_unit_if: request/result bundle between the EX stage and md_unit.
//   A, B   operands from the register-file read ports (rs, rt)
//   MDop   operation code (see md_pkg)
//   start  request, sampled on the rising clock edge
//   busy   high while an iterative operation is in flight
//   HI, LO architectural HI/LO registers
// master: EX-stage / hazard-unit side; slave: md_unit.
interface md_unit_if #(
  parameter int WIDTH = 32
);

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       MDop;
  logic             start;
  logic             busy;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output A, B, MDop, start,
    input  busy, HI, LO
  );

  modport slave (
    input  A, B, MDop, start,
    output busy, HI, LO
  );

endinterface

// File: rtl/md_signfix.sv
// md_signfix: combinational magnitude / negate helper.
//   a, b          two W-bit lanes
//   neg_a, neg_b  negate the corresponding lane (two's complement)
//   wide          treat {b, a} as one 2W-bit value, negated when neg_a
//                 is set (neg_b is ignored in this mode)
//   fix_a, fix_b  corrected lanes
// Used on the input side to take |A| and |B|, and on the output side to
// sign-correct either a double-width product or a quotient/remainder pair.
module md_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         neg_a,
  input  logic         neg_b,
  input  logic         wide,
  output logic [W-1:0] fix_a,
  output logic [W-1:0] fix_b
);

  logic [2*W-1:0] joint;

  assign joint = neg_a ? -{b, a} : {b, a};

  assign fix_a = wide ? joint[W-1:0]   : (neg_a ? -a : a);
  assign fix_b = wide ? joint[2*W-1:W] : (neg_b ? -b : b);

endmodule

// File: rtl/md_unit.sv
// md_unit: iterative multiply/divide unit beside the ALU in EX.
//   clk  system clock, rising edge
//   rst  synchronous, active-low reset
//   md   slave side of md_unit_if (A, B, MDop, start in; busy, HI, LO out)
// MULT/MULTU/DIV/DIVU take WIDTH cycles after the accepting edge; busy is
// high for exactly that long and HI/LO change only at the final edge.
// MTHI/MTLO write their register at the accepting edge without going busy.
// All outputs are registered.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  md_unit_if.slave  md
);

  localparam int CW = $clog2(WIDTH);

  md_state_e        state;
  md_state_e        state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  // Iteration datapath. Multiply: {work_hi, work_lo} is the partial
  // product with the multiplier shifting out of the bottom, opnd is the
  // multiplicand. Divide: work_hi is the partial remainder, work_lo the
  // dividend shifting out / quotient shifting in, opnd is the divisor.
  logic [WIDTH-1:0] work_hi;
  logic [WIDTH-1:0] work_lo;
  logic [WIDTH-1:0] opnd;
  logic             neg_res;   // signed op with differing operand signs
  logic             neg_rem;   // signed op with negative dividend
  logic             div_zero;

  logic             accept;
  logic             is_mul_op;
  logic             is_div_op;
  logic             sgn_op;
  logic             last;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem_next;
  logic [WIDTH-1:0]   div_quo_next;

  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic [WIDTH-1:0] fix_lo;
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  assign is_mul_op = (md.MDop == MD_MULT) || (md.MDop == MD_MULTU);
  assign is_div_op = (md.MDop == MD_DIV)  || (md.MDop == MD_DIVU);
  assign sgn_op    = op_is_signed(md.MDop);
  assign accept    = md.start && (state == IDLE);
  assign last      = (cnt == CW'(WIDTH - 1));

  // Operand pre-processing: magnitudes for signed ops.
  md_signfix #(.W(WIDTH)) u_fix_in (
    .a     (md.A),
    .b     (md.B),
    .neg_a (sgn_op && md.A[WIDTH-1]),
    .neg_b (sgn_op && md.B[WIDTH-1]),
    .wide  (1'b0),
    .fix_a (a_mag),
    .fix_b (b_mag)
  );

  // One shift-add multiply step and one restoring divide step.
  assign mul_sum  = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd} : '0);
  assign mul_next = {mul_sum, work_lo[WIDTH-1:1]};

  assign div_shift    = {work_hi, work_lo[WIDTH-1]};
  assign div_diff     = div_shift - {1'b0, opnd};
  assign div_ge       = !div_diff[WIDTH];
  assign div_rem_next = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_quo_next = {work_lo[WIDTH-2:0], div_ge};

  // Result correction works on the value the final step produces, so the
  // corrected result lands in HI/LO at the same edge as the last step.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned and infers a latch.
    out_a = div_quo_next;
    out_b = div_rem_next;
    if (state == MUL) begin
      out_a = mul_next[WIDTH-1:0];
      out_b = mul_next[2*WIDTH-1:WIDTH];
    end
  end

  md_signfix #(.W(WIDTH)) u_fix_out (
    .a     (out_a),
    .b     (out_b),
    .neg_a (neg_res),
    .neg_b (neg_rem),
    .wide  (state == MUL),
    .fix_a (fix_lo),
    .fix_b (fix_hi)
  );

  // Divide by zero: the magnitude algorithm leaves |A| in the remainder,
  // and the dividend-sign correction turns that back into the raw A, so
  // only the quotient needs overriding.
  always_comb begin
    res_lo = fix_lo;
    res_hi = fix_hi;
    if ((state == DIV) && div_zero) begin
      res_lo = '1;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && is_mul_op) begin
          state_next = MUL;
        end else if (accept && is_div_op) begin
          state_next = DIV;
        end
      end
      MUL, DIV: begin
        if (last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values regardless of statement order.
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Architectural HI/LO and the step counter. Reset in the middle of an
  // operation abandons it; HI/LO only ever change at an accepted MTHI/MTLO
  // or at the final step.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt  <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            case (md.MDop)
              MD_MTHI: hi_q <= md.A;
              MD_MTLO: lo_q <= md.A;
              MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: cnt <= '0;
              default: ;
            endcase
          end
        end
        MUL, DIV: begin
          cnt <= cnt + CW'(1);
          if (last) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the iteration datapath has no reset; it is fully loaded on every
  // accept and its contents are never observed while idle.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (accept && (is_mul_op || is_div_op)) begin
          work_hi  <= '0;
          work_lo  <= is_mul_op ? b_mag : a_mag;
          opnd     <= is_mul_op ? a_mag : b_mag;
          neg_res  <= sgn_op && (md.A[WIDTH-1] ^ md.B[WIDTH-1]);
          neg_rem  <= sgn_op && md.A[WIDTH-1];
          div_zero <= (md.B == '0);
        end
      end
      MUL: begin
        {work_hi, work_lo} <= mul_next;
      end
      DIV: begin
        work_hi <= div_rem_next;
        work_lo <= div_quo_next;
      end
      default: ;
    endcase
  end

  assign md.busy = (state != IDLE);
  assign md.HI   = hi_q;
  assign md.LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed vectors with a scoreboard. Stimulus pushes the
// expected HI/LO of each iterative op; a monitor pops and compares when
// busy falls, also checking busy length and HI/LO stability while busy.
module tb_md_unit;
  import md_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  exp_t sb[$];

  md_unit_if #(.WIDTH(32)) md ();

  md_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .md  (md)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge.
  logic        busy_prev;
  bit          in_op;
  int          busy_len;
  bit          hold_ok;
  logic [31:0] hold_hi;
  logic [31:0] hold_lo;

  always @(negedge clk) begin
    exp_t e;
    if (rst !== 1'b1) begin
      in_op     = 1'b0;
      busy_prev = 1'b0;
    end else begin
      if (md.busy === 1'b1 && busy_prev !== 1'b1) begin
        in_op    = 1'b1;
        busy_len = 0;
        hold_ok  = 1'b1;
        hold_hi  = md.HI;
        hold_lo  = md.LO;
      end
      if (md.busy === 1'b1) begin
        busy_len++;
        if (md.HI !== hold_hi || md.LO !== hold_lo) hold_ok = 1'b0;
      end
      if (md.busy === 1'b0 && busy_prev === 1'b1 && in_op) begin
        in_op = 1'b0;
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done: got completion expected none");
        end else begin
          e = sb.pop_front();
          check({e.name, "_hi"}, {32'b0, md.HI}, {32'b0, e.hi});
          check({e.name, "_lo"}, {32'b0, md.LO}, {32'b0, e.lo});
          check({e.name, "_busy_len"}, 64'(busy_len), 64'(MD_LAT));
          check({e.name, "_hold"}, {63'b0, hold_ok}, 64'd1);
        end
      end
      busy_prev = md.busy;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (md.busy !== 1'b0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_idle: got busy after %0d cycles expected idle", n);
    end
  endtask

  // Issues one request at the next edge. Iterative ops push their expected
  // result when want_result is set and must raise busy at that edge.
  task automatic issue(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                       input bit want_result);
    exp_t e;
    wait_idle();
    md.start = 1'b1;
    md.MDop  = op;
    md.A     = a;
    md.B     = b;
    if (want_result) begin
      e.name = name;
      e.hi   = ehi;
      e.lo   = elo;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    md.start = 1'b0;
    if (op <= 3'b011) check({name, "_accept"}, {63'b0, md.busy}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst      = 1'b0;
    md.start = 1'b0;
    md.MDop  = 3'b000;
    md.A     = '0;
    md.B     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hi", {32'b0, md.HI}, 64'd0);
    check("reset_lo", {32'b0, md.LO}, 64'd0);
    check("reset_busy", {63'b0, md.busy}, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Back-to-back iterative ops (each accepted at the first idle edge).
    issue("multu_max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1);
    issue("mult_neg",  MD_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1);
    issue("div_neg",   MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1);
    issue("div_negb",  MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1);
    issue("divu",      MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1);
    issue("divu_zero", MD_DIVU,  32'h12345678, 32'h0,        32'h12345678, 32'hFFFFFFFF, 1);
    issue("div_zero",  MD_DIV,   32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1);
    issue("div_ovf",   MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1);
    wait_idle();
    @(posedge clk); #1;

    // MTHI / MTLO: written at the accepting edge, busy stays low.
    issue("mthi", MD_MTHI, 32'hAAAA5555, 32'h0, 32'h0, 32'h0, 0);
    check("mthi_hi", {32'b0, md.HI}, {32'b0, 32'hAAAA5555});
    check("mthi_lo", {32'b0, md.LO}, {32'b0, 32'h80000000});
    check("mthi_busy", {63'b0, md.busy}, 64'd0);
    issue("mtlo", MD_MTLO, 32'h0F0F0F0F, 32'h0, 32'h0, 32'h0, 0);
    check("mtlo_lo", {32'b0, md.LO}, {32'b0, 32'h0F0F0F0F});
    check("mtlo_hi", {32'b0, md.HI}, {32'b0, 32'hAAAA5555});
    check("mtlo_busy", {63'b0, md.busy}, 64'd0);

    // Undefined opcode is a no-op.
    issue("undef", 3'b110, 32'hDEADBEEF, 32'h1, 32'h0, 32'h0, 0);
    check("undef_hi", {32'b0, md.HI}, {32'b0, 32'hAAAA5555});
    check("undef_lo", {32'b0, md.LO}, {32'b0, 32'h0F0F0F0F});
    check("undef_busy", {63'b0, md.busy}, 64'd0);

    // MTLO while busy is ignored; LO ends as the product.
    issue("mult_block", MD_MULT, 32'h00001234, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFDB98, 1);
    repeat (9) begin @(posedge clk); #1; end
    md.start = 1'b1;
    md.MDop  = MD_MTLO;
    md.A     = 32'h00000001;
    @(posedge clk); #1;
    md.start = 1'b0;
    check("busy_ignore_start", {63'b0, md.busy}, 64'd1);
    wait_idle();
    @(posedge clk); #1;

    // Reset mid-operation abandons the op and clears HI/LO.
    issue("multu_abort", MD_MULTU, 32'd3, 32'd5, 32'h0, 32'h0, 0);
    repeat (15) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_hi", {32'b0, md.HI}, 64'd0);
    check("abort_lo", {32'b0, md.LO}, 64'd0);
    check("abort_busy", {63'b0, md.busy}, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    issue("multu_small", MD_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1);
    wait_idle();
    repeat (3) begin @(posedge clk); #1; end

    check("sb_drain", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Iterative multiply/divide unit sitting beside the ALU in the EX stage of the MIPS datapath.
- Takes the same A/B operands the ALU receives from the register-file read ports and executes MULT/MULTU/DIV/DIVU over 32 cycles.
- Writes the HI/LO register pair and also handles MTHI/MTLO.
- HI/LO feed the writeback mux for MFHI/MFLO; `busy` feeds the hazard unit, which stalls any HI/LO access while an operation is in flight.

Parameters:
- WIDTH, 32, operand width; HI/LO are each WIDTH bits; iteration count equals WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-low reset
- A  in  WIDTH  operand 1 (rs); dividend or multiplicand; source for MTHI/MTLO
- B  in  WIDTH  operand 2 (rt); divisor or multiplier
- MDop  in  3  operation code: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others are no-op
- start  in  1  request; sampled on rising edge
- busy  out  1  high while an iterative operation is in flight
- HI  out  WIDTH  HI register (product high half / remainder)
- LO  out  WIDTH  LO register (product low half / quotient)

Behaviour:
- Reset (rst==0 at a rising edge): HI=0, LO=0, busy=0, FSM to IDLE, counter=0. Reset mid-operation abandons the operation and does not update HI/LO.
- FSM states: IDLE, MUL, DIV.
- Accept rule: start is honoured only when busy==0. A start while busy is ignored, with no queueing and no effect on the current operation.
- MTHI/MTLO: on an accepted start, HI<=A or LO<=A at that edge. busy stays 0 and the other register is unchanged.
- MULT/MULTU/DIV/DIVU accepted at edge E0:
  - latch operands; signed ops use magnitudes |A| and |B|, plus sign flags
  - counter<=0, busy<=1, state -> MUL or DIV
- Iteration: one step per cycle. Edges E1..E32 perform steps 0..31.
- Completion: at edge E32, HI/LO are written with the sign-corrected result, busy<=0, and state -> IDLE.
  - busy is high for exactly 32 cycles.
  - HI/LO hold their old values until E32, and new values are visible after E32.
  - start may be accepted again at the first edge where busy==0, i.e. E33.
- Multiply: shift-add on magnitudes, producing a 2*WIDTH product.
  - Signed op with operand signs differing: the 64-bit product is two's-complement negated.
  - {HI,LO} = product.
- Divide: restoring division on magnitudes.
  - Signed op: quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
  - LO = quotient, HI = remainder.
- Divide by zero (B==0, signed or unsigned): same 32-cycle latency; LO=32'hFFFFFFFF, HI=A (raw, uncorrected).
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. This is the natural result of the magnitude algorithm; no trap.
- Undefined MDop (110, 111) with start: ignored.
- No outputs are combinational from inputs. HI, LO and busy are all registered.

Decomposition:
- Shared package md_pkg: MDop encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO), FSM state typedef (IDLE/MUL/DIV), constant MD_LAT=32.
- One natural sub-module, md_signfix: combinational magnitude/negate helper for operand pre-processing and result correction, instantiated once on the input side and once on the output side.
- The iteration datapath stays in md_unit.

Test Plan:
- Reset, then MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> busy high 32 cycles; after E32 HI=0xFFFFFFFE, LO=0x00000001.
- MULT A=0xFFFFFFFD (-3) B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21); HI/LO unchanged during busy.
- DIV A=0xFFFFFFF9 (-7) B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU A=100 B=7 -> LO=14, HI=2.
- DIVU A=0x12345678 B=0 -> LO=0xFFFFFFFF, HI=0x12345678. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI A=0xAAAA5555 and then MTLO A=0x0F0F0F0F, each with busy=0 -> registers written next edge, busy never rises. Issue MULT, then at cycle 10 start MTLO A=0x1 -> ignored; final LO is the product.
- Start MULTU 3*5, assert rst=0 at cycle 16 -> HI=LO=0 and busy=0 next edge. New MULTU 3*5 completes 32 cycles later with LO=15, HI=0.
